// File: rtl/avmm_lvds_bridge_avm_if.sv
// -----------------------------------------------------------------------------
// avmm_lvds_bridge_avm_if
//
// Remote-end responder of the AVMM-over-LVDS bridge. Request packets are popped
// from the RX FIFO: one header word, followed by one write-data word per beat
// for writes. Each request is replayed on an Avalon-MM master, and the response
// packet is pushed into the TX FIFO:
//   write           -> header only
//   NOBURST read    -> header + 1 data word
//   BURST read      -> header + burstcount data words
// The response header is the request header echoed unchanged.
//
// Request header word layout:
//   [31]                   1 = read, 0 = write
//   [30]                   1 = BURST, 0 = NOBURST
//   [29:22]                burstcnt_byteena: burstcount (BURST) or byteenable[3:0] (NOBURST)
//   [ADDR_W-1:0]           Avalon word address
// The field positions are fixed, so ADDR_W <= 22 and BURSTCNT_W <= 8.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_rdreq_o           RX FIFO read request (q valid one clock later)
//   req_q_i               RX FIFO data
//   req_rdempty_i         RX FIFO empty
//   resp_data_o           TX FIFO write data (registered)
//   resp_valid_o          TX FIFO write strobe (registered, no backpressure)
//   m_*                   Avalon-MM master (address, byteenable, burstcount,
//                         writedata, write, read, readdata, waitrequest,
//                         readdatavalid)
// -----------------------------------------------------------------------------
module avmm_lvds_bridge_avm_if #(
    parameter int ADDR_W     = 22,
    parameter int BURSTCNT_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  req_rdreq_o,
    input  logic [31:0]           req_q_i,
    input  logic                  req_rdempty_i,
    output logic [31:0]           resp_data_o,
    output logic                  resp_valid_o,
    output logic [ADDR_W-1:0]     m_address_o,
    output logic [3:0]            m_byteenable_o,
    output logic [BURSTCNT_W-1:0] m_burstcount_o,
    output logic [31:0]           m_writedata_o,
    output logic                  m_write_o,
    output logic                  m_read_o,
    input  logic [31:0]           m_readdata_i,
    input  logic                  m_waitrequest_i,
    input  logic                  m_readdatavalid_i
);

    localparam int HDR_RD_BIT    = 31;
    localparam int HDR_BURST_BIT = 30;
    localparam int HDR_BCE_LSB   = 22;

    localparam logic [BURSTCNT_W-1:0] ONE_BEAT = BURSTCNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR      = 3'd1,
        ST_WR_FETCH = 3'd2,
        ST_WR_LOAD  = 3'd3,
        ST_WR_BUS   = 3'd4,
        ST_RESP_HDR = 3'd5,
        ST_RD_CMD   = 3'd6,
        ST_RD_DATA  = 3'd7
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;

    logic [31:0]             hdr_reg;
    logic [ADDR_W-1:0]       addr_reg;
    logic [3:0]              be_reg;
    logic [BURSTCNT_W-1:0]   bc_reg;
    logic [31:0]             wdata_reg;
    logic [BURSTCNT_W-1:0]   beat_cnt_reg;
    logic [31:0]             resp_data_reg;
    logic                    resp_valid_reg;

    logic [BURSTCNT_W-1:0]   beat_inc;
    logic                    last_beat;
    logic                    wr_accept;
    logic                    rd_accept;
    logic                    push_valid;
    logic [31:0]             push_data;
    logic [BURSTCNT_W-1:0]   bc_load;
    logic [3:0]              be_load;

    assign beat_inc  = beat_cnt_reg + ONE_BEAT;
    assign last_beat = (beat_inc == bc_reg);
    assign wr_accept = (state_reg == ST_WR_BUS) && !m_waitrequest_i;
    assign rd_accept = (state_reg == ST_RD_CMD) && !m_waitrequest_i;

    // Decode of the header being latched in HDR. A BURST with burstcount 0 is
    // executed (and presented on the bus) as a single beat.
    always_comb begin
        bc_load = ONE_BEAT;
        be_load = req_q_i[HDR_BCE_LSB +: 4];
        if (req_q_i[HDR_BURST_BIT]) begin
            be_load = 4'hF;
            if (req_q_i[HDR_BCE_LSB +: BURSTCNT_W] != '0) begin
                bc_load = req_q_i[HDR_BCE_LSB +: BURSTCNT_W];
            end
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (!req_rdempty_i) state_next = ST_HDR;
            ST_HDR:      state_next = req_q_i[HDR_RD_BIT] ? ST_RD_CMD : ST_WR_FETCH;
            ST_WR_FETCH: if (!req_rdempty_i) state_next = ST_WR_LOAD;
            ST_WR_LOAD:  state_next = ST_WR_BUS;
            ST_WR_BUS:   if (!m_waitrequest_i) state_next = last_beat ? ST_RESP_HDR : ST_WR_FETCH;
            ST_RESP_HDR: state_next = ST_IDLE;
            ST_RD_CMD:   if (!m_waitrequest_i) state_next = ST_RD_DATA;
            ST_RD_DATA:  if (m_readdatavalid_i && last_beat) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: output logic ----------------
    // The read request is combinational so the FIFO word is valid in the very
    // next state; it is gated by reset so that every output is low in reset.
    always_comb begin
        req_rdreq_o = 1'b0;
        m_write_o   = 1'b0;
        m_read_o    = 1'b0;
        push_valid  = 1'b0;
        push_data   = hdr_reg;
        case (state_reg)
            ST_IDLE:     req_rdreq_o = !req_rdempty_i && !rst_i;
            ST_WR_FETCH: req_rdreq_o = !req_rdempty_i && !rst_i;
            ST_WR_BUS:   m_write_o   = 1'b1;
            ST_RESP_HDR: push_valid  = 1'b1;
            ST_RD_CMD: begin
                m_read_o   = 1'b1;
                push_valid = !m_waitrequest_i;
            end
            ST_RD_DATA: begin
                push_valid = m_readdatavalid_i;
                push_data  = m_readdata_i;
            end
            default: ;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hdr_reg        <= '0;
            addr_reg       <= '0;
            be_reg         <= '0;
            bc_reg         <= '0;
            wdata_reg      <= '0;
            beat_cnt_reg   <= '0;
            resp_data_reg  <= '0;
            resp_valid_reg <= 1'b0;
        end else begin
            resp_valid_reg <= push_valid;
            if (push_valid) begin
                resp_data_reg <= push_data;
            end

            if (state_reg == ST_HDR) begin
                hdr_reg      <= req_q_i;
                addr_reg     <= req_q_i[ADDR_W-1:0];
                be_reg       <= be_load;
                bc_reg       <= bc_load;
                beat_cnt_reg <= '0;
            end

            if (state_reg == ST_WR_LOAD) begin
                wdata_reg <= req_q_i;
            end

            // rd_accept does not advance the count: only returned data does.
            if (wr_accept || ((state_reg == ST_RD_DATA) && m_readdatavalid_i)) begin
                beat_cnt_reg <= beat_inc;
            end
        end
    end

    assign resp_data_o    = resp_data_reg;
    assign resp_valid_o   = resp_valid_reg;
    assign m_address_o    = addr_reg;
    assign m_byteenable_o = be_reg;
    assign m_burstcount_o = bc_reg;
    assign m_writedata_o  = wdata_reg;

    // rd_accept is folded into push_valid; keep it referenced for readability.
    logic unused_rd_accept;
    assign unused_rd_accept = rd_accept;

endmodule
